// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts one complex sample (x, y) in signed 20.44
// fixed point into magnitude sqrt(x^2+y^2) and phase atan2(y, x), one micro-rotation per clock.
module cordic_vector #(
  parameter int DW    = 64,
  parameter int FW    = 44,
  parameter int NITER = 45
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] mag_o,
  output logic signed [DW-1:0] phase_o
);

  localparam int IW = (NITER > 1) ? $clog2(NITER) : 1;

  localparam logic signed [DW-1:0] PI   = DW'(64'h00003243F6A8885A);
  localparam logic signed [DW-1:0] COEF = DW'(64'h000009B74EDA8436);

  typedef enum logic [2:0] {
    IDLE,
    FOLD,
    ITER,
    SCALE,
    HOLD
  } state_t;

  // round(atan(2^-i) * 2^44); beyond i=14 the cubic term rounds away, leaving 2^(44-i).
  function automatic logic signed [DW-1:0] atan_val(input int idx);
    logic [63:0] v;
    case (idx)
      0:       v = 64'h00000C90FDAA2217;
      1:       v = 64'h0000076B19C1586F;
      2:       v = 64'h000003EB6EBF2590;
      3:       v = 64'h000001FD5BA9AAC3;
      4:       v = 64'h000000FFAADDB968;
      5:       v = 64'h0000007FF556EEA6;
      6:       v = 64'h0000003FFEAAB777;
      7:       v = 64'h0000001FFFD555BC;
      8:       v = 64'h0000000FFFFAAAAE;
      9:       v = 64'h00000007FFFF5555;
      10:      v = 64'h00000003FFFFEAAB;
      11:      v = 64'h00000001FFFFFD55;
      12:      v = 64'h00000000FFFFFFAB;
      13:      v = 64'h000000007FFFFFF5;
      14:      v = 64'h000000003FFFFFFF;
      default: v = 64'd1 << (44 - idx);
    endcase
    return DW'(v);
  endfunction

  logic signed [DW-1:0] atan_rom [NITER];

  generate
    for (genvar gi = 0; gi < NITER; gi++) begin : g_atan_rom
      assign atan_rom[gi] = atan_val(gi);
    end
  endgenerate

  state_t               state_reg, state_next;
  logic signed [DW-1:0] x_reg, x_next;
  logic signed [DW-1:0] y_reg, y_next;
  logic signed [DW-1:0] z_reg, z_next;
  logic [IW-1:0]        iter_reg, iter_next;
  logic                 zero_reg, zero_next;
  logic                 in_ready_reg, in_ready_next;
  logic                 out_valid_reg, out_valid_next;
  logic signed [DW-1:0] mag_reg, mag_next;
  logic signed [DW-1:0] phase_reg, phase_next;

  logic signed [DW-1:0]   x_shift, y_shift;
  logic signed [2*DW-1:0] x_wide, coef_wide, prod;

  assign x_shift   = x_reg >>> iter_reg;
  assign y_shift   = y_reg >>> iter_reg;
  assign x_wide    = {{DW{x_reg[DW-1]}}, x_reg};
  assign coef_wide = {{DW{COEF[DW-1]}}, COEF};
  assign prod      = x_wide * coef_wide;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      iter_reg      <= '0;
      zero_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      mag_reg       <= '0;
      phase_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      z_reg         <= z_next;
      iter_reg      <= iter_next;
      zero_reg      <= zero_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      mag_reg       <= mag_next;
      phase_reg     <= phase_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    z_next         = z_reg;
    iter_next      = iter_reg;
    zero_next      = zero_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;
    mag_next       = mag_reg;
    phase_next     = phase_reg;

    case (state_reg)
      IDLE: begin
        in_ready_next = 1'b1;
        if (in_valid && in_ready_reg) begin
          x_next        = x_i;
          y_next        = y_i;
          z_next        = '0;
          zero_next     = (x_i == 0) && (y_i == 0);
          in_ready_next = 1'b0;
          state_next    = FOLD;
        end
      end

      // Left half-plane is mirrored through the origin; y>=0 maps to +PI so the negative real axis never yields -PI.
      FOLD: begin
        if (x_reg < 0) begin
          x_next = -x_reg;
          y_next = -y_reg;
          z_next = (y_reg >= 0) ? PI : -PI;
        end
        iter_next  = '0;
        state_next = ITER;
      end

      ITER: begin
        if (y_reg >= 0) begin
          x_next = x_reg + y_shift;
          y_next = y_reg - x_shift;
          z_next = z_reg + atan_rom[iter_reg];
        end else begin
          x_next = x_reg - y_shift;
          y_next = y_reg + x_shift;
          z_next = z_reg - atan_rom[iter_reg];
        end
        iter_next = iter_reg + 1'b1;
        if (iter_reg == IW'(NITER - 1)) begin
          state_next = SCALE;
        end
      end

      SCALE: begin
        mag_next       = DW'(prod >>> FW);
        phase_next     = zero_reg ? '0 : z_reg;
        out_valid_next = 1'b1;
        state_next     = HOLD;
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign mag_o     = mag_reg;
  assign phase_o   = phase_reg;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: hand-computed magnitude/phase vectors,
// fixed latency, backpressure, and asynchronous reset in the middle of a sample.
module tb_cordic_vector;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic signed [63:0] x_i = '0;
  logic signed [63:0] y_i = '0;
  logic signed [63:0] mag_o;
  logic signed [63:0] phase_o;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic signed [63:0] ONE    = 64'sh0000100000000000;
  localparam logic signed [63:0] PI     = 64'sh00003243F6A8885A;
  localparam logic signed [63:0] PI2    = 64'sh00001921FB54442D;
  localparam logic signed [63:0] PH_3_4 = 64'sh00000ED63382B0DD;
  localparam logic signed [63:0] PI3_4  = 64'sh000025B2F8FE6644;
  localparam logic signed [63:0] MAG_55 = 64'sh0000712318007C2B;
  localparam logic signed [63:0] JUNK   = 64'sh0000555500000000;
  localparam longint             TOL    = 4096;

  always #5 clk = ~clk;

  cordic_vector #(
    .DW(64),
    .FW(44),
    .NITER(45)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_i(x_i),
    .y_i(y_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_o(mag_o),
    .phase_o(phase_o)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp, input longint tol);
    longint diff;
    tests_run++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [63:0] xv, input logic signed [63:0] yv);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    check("in_ready_before_send", 64'(in_ready), 64'd1, 0);
    in_valid = 1'b1;
    x_i      = xv;
    y_i      = yv;
    step();
    in_valid = 1'b0;
    x_i      = JUNK;
    y_i      = -JUNK;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0, 0);
    check("in_ready_return", 64'(in_ready), 64'd1, 0);
  endtask

  task automatic run(input string name, input logic signed [63:0] xv, input logic signed [63:0] yv,
                     input logic signed [63:0] em, input logic signed [63:0] ep,
                     input longint tm, input longint tp);
    int lat;
    send(xv, yv);
    wait_out(lat);
    check({name, "_latency"}, 64'(lat), 64'd47, 0);
    check({name, "_mag"}, mag_o, em, tm);
    check({name, "_phase"}, phase_o, ep, tp);
    $display("[TB] %s: x=%h y=%h mag=%h phase=%h latency=%0d", name, xv, yv, mag_o, phase_o, lat);
    finish_out();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0, 0);
    check("rst_out_valid", 64'(out_valid), 64'd0, 0);
    check("rst_mag", mag_o, 64'sd0, 0);
    check("rst_phase", phase_o, 64'sd0, 0);
    step();
    step();
    check("rst_held_in_ready", 64'(in_ready), 64'd0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("in_ready_first_edge", 64'(in_ready), 64'd1, 0);
    $display("[TB] reset released, in_ready=%0d", in_ready);

    run("q1_3_4", 3 * ONE, 4 * ONE, 5 * ONE, PH_3_4, 5 * TOL, TOL);
    run("neg_x_axis", -ONE, 64'sd0, ONE, PI, TOL, TOL);
    run("neg_x_below", -ONE, -64'sd1, ONE, -PI, TOL, TOL);
    run("neg_y_axis", 64'sd0, -2 * ONE, 2 * ONE, -PI2, 2 * TOL, TOL);
    run("q3_diag", -5 * ONE, -5 * ONE, MAG_55, -PI3_4, 8 * TOL, TOL);
    run("zero", 64'sd0, 64'sd0, 64'sd0, 64'sd0, 0, 0);
    run("pos_y_axis", 64'sd0, 3 * ONE, 3 * ONE, PI2, 3 * TOL, TOL);
    run("max_x", ONE <<< 17, 64'sd0, ONE <<< 17, 64'sd0, TOL <<< 17, TOL);

    // Backpressure: result must sit still while a competing input is offered.
    send(3 * ONE, 4 * ONE);
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd47, 0);
    in_valid = 1'b1;
    x_i      = -7 * ONE;
    y_i      = ONE;
    for (int c = 0; c < 20; c++) begin
      step();
      check("bp_out_valid", 64'(out_valid), 64'd1, 0);
      check("bp_in_ready", 64'(in_ready), 64'd0, 0);
      check("bp_mag", mag_o, 5 * ONE, 5 * TOL);
      check("bp_phase", phase_o, PH_3_4, TOL);
    end
    $display("[TB] backpressure: held 20 cycles mag=%h phase=%h", mag_o, phase_o);
    x_i       = 64'sd0;
    y_i       = -2 * ONE;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_out_valid_drop", 64'(out_valid), 64'd0, 0);
    check("bp_in_ready_next", 64'(in_ready), 64'd1, 0);
    step();
    in_valid = 1'b0;
    x_i      = JUNK;
    y_i      = JUNK;
    wait_out(lat);
    check("b2b_latency", 64'(lat), 64'd47, 0);
    check("b2b_mag", mag_o, 2 * ONE, 2 * TOL);
    check("b2b_phase", phase_o, -PI2, TOL);
    $display("[TB] back_to_back: mag=%h phase=%h latency=%0d", mag_o, phase_o, lat);
    finish_out();

    // Reset while iteration 20 is in flight.
    send(3 * ONE, 4 * ONE);
    repeat (21) step();
    rstn = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0, 0);
    check("midrst_out_valid", 64'(out_valid), 64'd0, 0);
    check("midrst_mag", mag_o, 64'sd0, 0);
    check("midrst_phase", phase_o, 64'sd0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("midrst_in_ready_first_edge", 64'(in_ready), 64'd1, 0);
    seen = 0;
    repeat (60) begin
      step();
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", 64'(seen), 64'd0, 0);
    $display("[TB] mid_reset: dropped sample produced output=%0d", seen);
    run("after_reset", -5 * ONE, -5 * ONE, MAG_55, -PI3_4, 8 * TOL, TOL);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
